// File: rtl/vga_box_plotter.sv
// Box plotter for the VGA adapter: draws a BOX_W x BOX_H box (clipped to screen) or clears the screen,
// one pixel per cycle. Optional outline-only mode enabled by VGA_BOX_OUTLINE_EN.
module vga_box_plotter #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int X_W             = 8,
    parameter int Y_W             = 7,
    parameter int BOX_W           = 4,
    parameter int BOX_H           = 4,
    parameter int COLOUR_W        = 3
) (
    input  logic                iClock,
    input  logic                iResetn,
    input  logic                iLoadX,
    input  logic                iPlotBox,
    input  logic                iBlack,
`ifdef VGA_BOX_OUTLINE_EN
    input  logic                iOutline,
`endif
    input  logic [COLOUR_W-1:0] iColour,
    input  logic [X_W-1:0]      iXY_Coord,
    output logic [X_W-1:0]      oX,
    output logic [Y_W-1:0]      oY,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oPlot,
    output logic                oBusy,
    output logic                oDone
);

    typedef enum logic [1:0] {IDLE, DRAW, CLEAR, DONE} state_t;

    localparam logic [X_W-1:0] BX_LAST = X_W'(BOX_W - 1);
    localparam logic [Y_W-1:0] BY_LAST = Y_W'(BOX_H - 1);
    localparam logic [X_W-1:0] SX_LAST = X_W'(X_SCREEN_PIXELS - 1);
    localparam logic [Y_W-1:0] SY_LAST = Y_W'(Y_SCREEN_PIXELS - 1);
    localparam logic [X_W:0]   X_LIM   = (X_W+1)'(X_SCREEN_PIXELS);
    localparam logic [Y_W:0]   Y_LIM   = (Y_W+1)'(Y_SCREEN_PIXELS);

    state_t              state, nxt_state;
    logic [X_W-1:0]      x0, nxt_x0, dx, nxt_dx;
    logic [Y_W-1:0]      y0, nxt_y0, dy, nxt_dy;
    logic [COLOUR_W-1:0] col, nxt_col;
    logic                outline, nxt_outline, outline_in;
    logic                plot_q, black_q, armed;
    logic                plot_rise, black_rise;
    logic [X_W:0]        x_sum;
    logic [Y_W:0]        y_sum;
    logic                border, on_screen, draw_plot;

`ifdef VGA_BOX_OUTLINE_EN
    assign outline_in = iOutline;
`else
    assign outline_in = 1'b0;
`endif

    // armed blocks the first cycle after reset so a level held through release is not seen as an edge
    assign plot_rise  = armed & iPlotBox & ~plot_q;
    assign black_rise = armed & iBlack & ~black_q;

    always_comb begin
        nxt_state   = state;
        nxt_x0      = x0;
        nxt_y0      = y0;
        nxt_col     = col;
        nxt_outline = outline;
        nxt_dx      = dx;
        nxt_dy      = dy;
        case (state)
            IDLE: begin
                if (iLoadX) nxt_x0 = iXY_Coord;
                if (black_rise) begin
                    nxt_state = CLEAR;
                    nxt_dx    = '0;
                    nxt_dy    = '0;
                end else if (plot_rise) begin
                    nxt_state   = DRAW;
                    nxt_y0      = iXY_Coord[Y_W-1:0];
                    nxt_col     = iColour;
                    nxt_outline = outline_in;
                    nxt_dx      = '0;
                    nxt_dy      = '0;
                end
            end
            DRAW: begin
                if (dx == BX_LAST) begin
                    nxt_dx = '0;
                    if (dy == BY_LAST) nxt_state = DONE;
                    else               nxt_dy = dy + 1'b1;
                end else begin
                    nxt_dx = dx + 1'b1;
                end
            end
            CLEAR: begin
                if (dx == SX_LAST) begin
                    nxt_dx = '0;
                    if (dy == SY_LAST) nxt_state = DONE;
                    else               nxt_dy = dy + 1'b1;
                end else begin
                    nxt_dx = dx + 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Pixel outputs are registered from the next-state values so they line up with the state
    always_comb begin
        x_sum     = {1'b0, nxt_x0} + {1'b0, nxt_dx};
        y_sum     = {1'b0, nxt_y0} + {1'b0, nxt_dy};
        border    = (nxt_dx == '0) || (nxt_dx == BX_LAST) || (nxt_dy == '0) || (nxt_dy == BY_LAST);
        on_screen = (x_sum < X_LIM) && (y_sum < Y_LIM);
        draw_plot = on_screen && (!nxt_outline || border);
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state   <= IDLE;
            x0      <= '0;
            y0      <= '0;
            col     <= '0;
            outline <= 1'b0;
            dx      <= '0;
            dy      <= '0;
            plot_q  <= 1'b0;
            black_q <= 1'b0;
            armed   <= 1'b0;
            oX      <= '0;
            oY      <= '0;
            oColour <= '0;
            oPlot   <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            state   <= nxt_state;
            x0      <= nxt_x0;
            y0      <= nxt_y0;
            col     <= nxt_col;
            outline <= nxt_outline;
            dx      <= nxt_dx;
            dy      <= nxt_dy;
            plot_q  <= iPlotBox;
            black_q <= iBlack;
            armed   <= 1'b1;
            oBusy   <= (nxt_state == DRAW) || (nxt_state == CLEAR);
            oDone   <= (nxt_state == DONE);
            case (nxt_state)
                DRAW: begin
                    oX      <= x_sum[X_W-1:0];
                    oY      <= y_sum[Y_W-1:0];
                    oColour <= nxt_col;
                    oPlot   <= draw_plot;
                end
                CLEAR: begin
                    oX      <= nxt_dx;
                    oY      <= nxt_dy;
                    oColour <= '0;
                    oPlot   <= 1'b1;
                end
                default: oPlot <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_box_plotter.sv
// Self-checking bench for vga_box_plotter: directed and random box draws, clipping, clear sweep,
// trigger priority, mid-draw reset; outline mode when VGA_BOX_OUTLINE_EN is defined.
module tb_vga_box_plotter;

    localparam int SX = 160;
    localparam int SY = 120;
    localparam int BW = 4;
    localparam int BH = 4;

    logic       iClock, iResetn, iLoadX, iPlotBox, iBlack;
    logic [2:0] iColour;
    logic [7:0] iXY_Coord;
    logic [7:0] oX;
    logic [6:0] oY;
    logic [2:0] oColour;
    logic       oPlot, oBusy, oDone;
`ifdef VGA_BOX_OUTLINE_EN
    logic       iOutline;
`endif

    int tests = 0;
    int fails = 0;

    vga_box_plotter dut (
        .iClock(iClock), .iResetn(iResetn), .iLoadX(iLoadX), .iPlotBox(iPlotBox), .iBlack(iBlack),
`ifdef VGA_BOX_OUTLINE_EN
        .iOutline(iOutline),
`endif
        .iColour(iColour), .iXY_Coord(iXY_Coord), .oX(oX), .oY(oY), .oColour(oColour),
        .oPlot(oPlot), .oBusy(oBusy), .oDone(oDone)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, 32'(oBusy), 0);
        chk({tag, " plot"}, 32'(oPlot), 0);
        chk({tag, " done"}, 32'(oDone), 0);
    endtask

    // mode 0: separate iLoadX cycle; mode 1: reuse current origin; mode 2: iLoadX on the trigger cycle
    task automatic do_draw(input int x0, input int y0, input int col, input bit outl, input int mode);
        int  x, y;
        bit  pl, brd, last_vis;
        if (mode == 0) begin
            iLoadX = 1'b1; iXY_Coord = 8'(x0);
            @(negedge iClock);
            iLoadX = 1'b0;
        end
        iLoadX    = (mode == 2);
        iXY_Coord = (mode == 2) ? 8'(x0) : 8'(y0);
        iColour   = 3'(col);
`ifdef VGA_BOX_OUTLINE_EN
        iOutline  = outl;
`endif
        iPlotBox  = 1'b1;
        @(negedge iClock);
        iLoadX   = 1'b0;
        iPlotBox = 1'b0;
        last_vis = 1'b0;
        for (int j = 0; j < BH; j++) begin
            for (int i = 0; i < BW; i++) begin
                x   = x0 + i;
                y   = y0 + j;
                brd = (i == 0) || (i == BW-1) || (j == 0) || (j == BH-1);
`ifdef VGA_BOX_OUTLINE_EN
                pl  = (x < SX) && (y < SY) && (!outl || brd);
`else
                pl  = (x < SX) && (y < SY) && (outl || !outl);
`endif
                last_vis = (x < SX) && (y < SY);
                chk("draw busy", 32'(oBusy), 1);
                chk("draw done", 32'(oDone), 0);
                chk("draw plot", 32'(oPlot), 32'(pl));
                chk("draw colour", 32'(oColour), 32'(col));
                if (pl) begin
                    chk("draw x", 32'(oX), 32'(x));
                    chk("draw y", 32'(oY), 32'(y));
                end
                @(negedge iClock);
            end
        end
        chk("draw done pulse", 32'(oDone), 1);
        chk("draw done busy", 32'(oBusy), 0);
        chk("draw done plot", 32'(oPlot), 0);
        if (last_vis) begin
            chk("draw hold x", 32'(oX), 32'(x0 + BW - 1));
            chk("draw hold y", 32'(oY), 32'(y0 + BH - 1));
        end
        @(negedge iClock);
        chk_idle("draw after done");
    endtask

    initial begin
        int x0, y0, col;
        iResetn = 1'b0; iLoadX = 1'b0; iPlotBox = 1'b0; iBlack = 1'b0;
        iColour = '0; iXY_Coord = '0;
`ifdef VGA_BOX_OUTLINE_EN
        iOutline = 1'b0;
`endif
        #12;
        chk("reset x", 32'(oX), 0);
        chk("reset y", 32'(oY), 0);
        chk("reset colour", 32'(oColour), 0);
        chk_idle("reset");
        @(negedge iClock);
        iResetn = 1'b1;
        repeat (2) @(negedge iClock);

        do_draw(10, 20, 5, 1'b0, 0);
        do_draw(158, 118, 2, 1'b0, 0);
        do_draw(50, 50, 3, 1'b0, 2);
        do_draw(200, 10, 7, 1'b0, 0);
`ifdef VGA_BOX_OUTLINE_EN
        do_draw(10, 20, 6, 1'b1, 0);
        do_draw(157, 117, 1, 1'b1, 0);
`endif
        for (int k = 0; k < 8; k++) begin
            x0  = int'($urandom_range(0, 255));
            y0  = int'($urandom_range(0, 127));
            col = int'($urandom_range(0, 7));
            do_draw(x0, y0, col, 1'b0, 0);
        end

        // Clear with simultaneous iPlotBox rise; later iPlotBox toggles must be ignored
        iBlack = 1'b1; iPlotBox = 1'b1; iXY_Coord = 8'd33; iColour = 3'd4;
        @(negedge iClock);
        for (int i = 0; i < SX*SY; i++) begin
            if (i == 100) iPlotBox = 1'b0;
            if (i == 200) iPlotBox = 1'b1;
            if (i == 300) iBlack = 1'b0;
            if (i % 4000 == 0 || i == SX*SY-1) begin
                chk("clear x", 32'(oX), 32'(i % SX));
                chk("clear y", 32'(oY), 32'(i / SX));
            end else begin
                tests++;
                assert (oX === 8'(i % SX) && oY === 7'(i / SX)) else begin
                    fails++;
                    $error("FAIL clear xy observed=%0d,%0d expected=%0d,%0d", oX, oY, i % SX, i / SX);
                end
            end
            tests++;
            assert (oPlot === 1'b1 && oColour === 3'd0 && oBusy === 1'b1 && oDone === 1'b0) else begin
                fails++;
                $error("FAIL clear flags observed=%b%b%b/%0d expected=110/0", oPlot, oBusy, oDone, oColour);
            end
            @(negedge iClock);
        end
        chk("clear done pulse", 32'(oDone), 1);
        chk("clear done plot", 32'(oPlot), 0);
        chk("clear hold x", 32'(oX), SX-1);
        chk("clear hold y", 32'(oY), SY-1);
        repeat (3) begin
            @(negedge iClock);
            chk_idle("after clear");
        end
        iPlotBox = 1'b0;
        @(negedge iClock);

        // Reset aborts a draw at pixel 7; held iPlotBox must not retrigger after release
        iLoadX = 1'b1; iXY_Coord = 8'd30;
        @(negedge iClock);
        iLoadX = 1'b0; iXY_Coord = 8'd40; iColour = 3'd6; iPlotBox = 1'b1;
        repeat (8) @(negedge iClock);
        chk("pre-reset x", 32'(oX), 33);
        chk("pre-reset y", 32'(oY), 41);
        #2 iResetn = 1'b0;
        #1;
        chk("async reset x", 32'(oX), 0);
        chk("async reset y", 32'(oY), 0);
        chk("async reset colour", 32'(oColour), 0);
        chk_idle("async reset");
        @(negedge iClock);
        iResetn = 1'b1;
        repeat (5) begin
            @(negedge iClock);
            chk_idle("held plotbox after reset");
        end
        iPlotBox = 1'b0;
        @(negedge iClock);
        do_draw(0, 40, 6, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_box_plotter.md
Name: vga_box_plotter

Overview:
- Parametrised successor of the fixed 4x4 box drawer in the VGA lab path.
- Captures a box origin and colour, then streams one pixel per cycle to the VGA adapter's x/y/colour/plot interface.
- Box size and screen size are parameters.
- Adds off-screen clipping, a full-screen clear sweep, busy/done status and a strict edge-triggered command handshake.

Parameters:
- X_SCREEN_PIXELS, 160, screen width in pixels.
- Y_SCREEN_PIXELS, 120, screen height in pixels.
- X_W, 8, width of oX and iXY_Coord.
- Y_W, 7, width of oY.
- BOX_W, 4, box width in pixels (1..X_SCREEN_PIXELS).
- BOX_H, 4, box height in pixels (1..Y_SCREEN_PIXELS).
- COLOUR_W, 3, pixel colour width.

Ports:
- iClock  in  1  single clock, all logic on rising edge.
- iResetn  in  1  asynchronous, active-low reset.
- iLoadX  in  1  level: while high in IDLE, origin X register <= iXY_Coord each cycle.
- iPlotBox  in  1  rising edge in IDLE: latch Y = iXY_Coord[Y_W-1:0], latch colour, start box draw.
- iBlack  in  1  rising edge in IDLE: start full-screen clear.
- iColour  in  COLOUR_W  box colour, sampled on the iPlotBox edge.
- iXY_Coord  in  X_W  shared X/Y coordinate input.
- oX  out  X_W  pixel X, registered.
- oY  out  Y_W  pixel Y, registered.
- oColour  out  COLOUR_W  pixel colour, registered.
- oPlot  out  1  pixel write enable, registered.
- oBusy  out  1  high in DRAW or CLEAR.
- oDone  out  1  one-cycle pulse when a draw or clear finishes.

Behaviour:
- Reset (async, iResetn=0):
  - state=IDLE.
  - oX, oY, oColour, oPlot, oBusy, oDone = 0.
  - Origin, colour and counter registers = 0.
  - Edge-detect flops for iPlotBox and iBlack = 0.
- Reset mid-operation aborts the operation immediately. No oDone is produced.
- Edge detection uses the previous-cycle registered copy of each input. An input held high through reset release does not trigger until it drops and rises again.
- States: IDLE, DRAW, CLEAR, DONE.
- IDLE:
  - iBlack rise -> CLEAR. iBlack has priority over iPlotBox when both rise in the same cycle.
  - Otherwise iPlotBox rise -> DRAW.
  - oPlot=0.
  - If iLoadX is high in the same cycle as the trigger edge, X is loaded and used.
- DRAW:
  - Counters dx in 0..BOX_W-1 and dy in 0..BOX_H-1, raster order, dx fastest.
  - Each cycle: oX=x0+dx, oY=y0+dy, oColour=latched colour.
  - Sums are computed one bit wider than the destination.
  - oPlot=1 only if x0+dx < X_SCREEN_PIXELS and y0+dy < Y_SCREEN_PIXELS. Clipped pixels still consume their cycle with oPlot=0 and never wrap around.
  - Takes exactly BOX_W*BOX_H cycles. The first pixel is presented the cycle after the trigger edge is sampled.
  - After dx=BOX_W-1, dy=BOX_H-1 -> DONE.
- CLEAR:
  - Sweeps x 0..X_SCREEN_PIXELS-1 and y 0..Y_SCREEN_PIXELS-1 in raster order.
  - oColour=0, oPlot=1 every cycle.
  - Takes exactly X_SCREEN_PIXELS*Y_SCREEN_PIXELS cycles, then -> DONE.
  - Latched origin and colour are unchanged.
- DONE:
  - One cycle: oDone=1, oPlot=0, oBusy=0, then -> IDLE.
  - oX/oY/oColour hold the last pixel values.
- Edges on iPlotBox/iBlack and iLoadX levels outside IDLE are ignored. Edges are not queued.
- oBusy=1 in DRAW and CLEAR only.

Optional Feature:
- Macro: VGA_BOX_OUTLINE_EN.
- Defined:
  - Adds input port iOutline (1 bit), sampled on the iPlotBox edge.
  - If latched high, DRAW asserts oPlot only for border pixels (dx=0, dx=BOX_W-1, dy=0 or dy=BOX_H-1), still subject to clipping.
  - Cycle count is unchanged (BOX_W*BOX_H).
  - CLEAR is unaffected.
- Undefined: no iOutline port; every in-screen box pixel is plotted (solid fill).

Test Plan:
- Box draw: iLoadX=1 with iXY_Coord=10 for one cycle, then iXY_Coord=20, iColour=5, iPlotBox 0->1 -> 16 consecutive oPlot=1 cycles with oColour=5, (10,20),(11,20)..(13,20),(10,21)..(13,23); next cycle oDone=1 for exactly one cycle.
- Clipping: X=158, Y=118, box plotted -> 16-cycle DRAW, oPlot=1 only at (158,118),(159,118),(158,119),(159,119); no wrapped coordinates.
- Clear: iBlack 0->1 -> 19200 cycles oPlot=1, oColour=0, first (0,0), last (159,119); then oDone pulse.
- Simultaneous/busy: iBlack and iPlotBox rise together -> CLEAR runs, no box. An iPlotBox pulse during CLEAR produces no draw afterwards.
- Reset: drive iResetn=0 asynchronously at DRAW pixel 7 -> all outputs 0 before the next clock edge, no oDone. After release, a held-high iPlotBox does not start a draw until it toggles.
- With VGA_BOX_OUTLINE_EN and iOutline=1: 4x4 box at (10,20) -> 12 plotted pixels; (11,21),(12,21),(11,22),(12,22) have oPlot=0; 16 cycles total.
